// File: rtl/spy_path_sequencer.sv
// -----------------------------------------------------------------------------
// spy_path_sequencer
//
// Measurement controller for a chained spy delay path. Each trial toggles the
// chain input, samples the chain output a programmable number of cycles later,
// and scores the sample as a hit (settled to the expected value) or a miss.
// A run is a host-requested number of such trials; hit/miss totals are held
// after the run until the next accepted start.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   begin a run (accepted only from IDLE, not in a done cycle)
//   capture_dly  in   launch-to-capture distance in cycles (0 behaves as 1)
//   num_trials   in   launches per run
//   busy         out  run in progress
//   done         out  one-cycle pulse at end of run
//   hit_count    out  captures equal to the expected settled value (saturating)
//   miss_count   out  captures not equal to the expected value (saturating)
//   path_in      out  drives the chain input
//   path_result  in   chain output (asynchronous, deliberately unsynchronised)
//   trace        out  [SPY_TRACE_EN only] per-trial hit history, LSB newest
//
// Build option: define SPY_TRACE_EN to add the 32-bit trace output.
// -----------------------------------------------------------------------------
module spy_path_sequencer #(
    parameter bit CHAIN_INVERTS = 1'b0,
    parameter int DLY_W         = 8,
    parameter int TRIAL_W       = 16,
    parameter int SETTLE_CYC    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DLY_W-1:0]   capture_dly,
    input  logic [TRIAL_W-1:0] num_trials,
    output logic               busy,
    output logic               done,
    output logic [TRIAL_W-1:0] hit_count,
    output logic [TRIAL_W-1:0] miss_count,
    output logic               path_in,
    input  logic               path_result
`ifdef SPY_TRACE_EN
    ,
    output logic [31:0]        trace
`endif
);

    // One down-counter serves both the capture wait and the settle gap, so it
    // must be wide enough for whichever of the two is larger.
    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int CNT_W = (DLY_W > SET_W) ? DLY_W : SET_W;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [TRIAL_W-1:0] CNT_MAX = {TRIAL_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        CAPTURE,
        SETTLE,
        FIN
    } state_e;

    state_e             state_q, state_d;
    logic [DLY_W-1:0]   dly_q, dly_d;
    logic [TRIAL_W-1:0] trials_q, trials_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TRIAL_W-1:0] hit_q, hit_d;
    logic [TRIAL_W-1:0] miss_q, miss_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               path_in_q, path_in_d;
    logic               expected_q, expected_d;
    // The chain output is sampled raw on purpose: the measurement is whether
    // it has settled by the capture edge. Timing treats this as a false path,
    // and the attribute stops the register being merged or optimised away.
    (* keep = "true" *) logic sample_q;
    logic               sample_d;
    logic               sample_match;
`ifdef SPY_TRACE_EN
    logic [31:0]        trace_q, trace_d;
`endif

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // through this block leaves one unassigned and infers a latch.
        state_d      = state_q;
        dly_d        = dly_q;
        trials_d     = trials_q;
        cnt_d        = cnt_q;
        hit_d        = hit_q;
        miss_d       = miss_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        path_in_d    = path_in_q;
        expected_d   = expected_q;
        sample_d     = sample_q;
        sample_match = (sample_q == expected_q);
`ifdef SPY_TRACE_EN
        trace_d      = trace_q;
`endif

        unique case (state_q)
            IDLE: begin
                // done_q high means the previous run is still closing out.
                if (start && !done_q) begin
                    dly_d    = (capture_dly == '0) ? DLY_W'(1) : capture_dly;
                    trials_d = num_trials;
                    hit_d    = '0;
                    miss_d   = '0;
                    busy_d   = 1'b1;
`ifdef SPY_TRACE_EN
                    trace_d  = '0;
`endif
                    state_d  = (num_trials == '0) ? FIN : LAUNCH;
                end
            end

            LAUNCH: begin
                path_in_d  = ~path_in_q;
                expected_d = ~path_in_q ^ CHAIN_INVERTS;
                cnt_d      = CNT_W'(dly_q - DLY_W'(1));
                state_d    = WAIT;
            end

            WAIT: begin
                // Leaving WAIT on this edge puts the sample exactly dly
                // edges after the edge that toggled path_in.
                if (cnt_q == '0) begin
                    sample_d = path_result;
                    state_d  = CAPTURE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            CAPTURE: begin
                if (sample_match) begin
                    if (hit_q != CNT_MAX) hit_d = hit_q + TRIAL_W'(1);
                end else begin
                    if (miss_q != CNT_MAX) miss_d = miss_q + TRIAL_W'(1);
                end
`ifdef SPY_TRACE_EN
                trace_d  = {trace_q[30:0], sample_match};
`endif
                trials_d = trials_q - TRIAL_W'(1);
                cnt_d    = SETTLE_LOAD;
                state_d  = SETTLE;
            end

            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = (trials_q != '0) ? LAUNCH : FIN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q    <= IDLE;
            dly_q      <= '0;
            trials_q   <= '0;
            cnt_q      <= '0;
            hit_q      <= '0;
            miss_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            path_in_q  <= 1'b0;
            expected_q <= 1'b0;
            sample_q   <= 1'b0;
`ifdef SPY_TRACE_EN
            trace_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            dly_q      <= dly_d;
            trials_q   <= trials_d;
            cnt_q      <= cnt_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            path_in_q  <= path_in_d;
            expected_q <= expected_d;
            sample_q   <= sample_d;
`ifdef SPY_TRACE_EN
            trace_q    <= trace_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;
    assign path_in    = path_in_q;
`ifdef SPY_TRACE_EN
    assign trace      = trace_q;
`endif

endmodule
